// File: rtl/axil_arbiter_wrr.sv
// AXI-Lite write-channel arbiter: fixed priority, round robin or weighted round robin.
// Define AXIL_ARB_TIMEOUT_EN to add the response watchdog (TIMEOUT_CYCLES).
module axil_arbiter_wrr #(
    parameter int N_MASTER       = 4,
    parameter int MODE           = 1,
    parameter int WEIGHT_W       = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W         = N_MASTER > 1 ? $clog2(N_MASTER) : 1
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [N_MASTER-1:0]          request,
    input  logic [N_MASTER*WEIGHT_W-1:0] weight,
    output logic [N_MASTER-1:0]          grant,
    output logic                         grant_valid,
    output logic [IDX_W-1:0]             grant_idx,
    input  logic                         s_axil_bvalid,
    input  logic [N_MASTER-1:0]          m_axil_bready,
    output logic                         timeout_err,
    output logic [IDX_W-1:0]             timeout_idx
);

    typedef enum logic {IDLE, ACKN} state_e;

    state_e                state_q, state_d;
    logic [N_MASTER-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [WEIGHT_W-1:0]   credit_q, credit_d;
    logic [IDX_W-1:0]      win;
    logic                  found;
    logic [WEIGHT_W-1:0]   win_w;
    logic                  rsp_hs;
    logic                  burst;
    logic                  rel;

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  terr_q, terr_d;
    logic [IDX_W-1:0]      tidx_q, tidx_d;
`endif

    assign rsp_hs = (state_q == ACKN) && s_axil_bvalid
                    && m_axil_bready[idx_q];
    assign burst  = (MODE == 2) && (credit_q > WEIGHT_W'(1))
                    && request[idx_q];
    assign win_w  = weight[int'(win)*WEIGHT_W +: WEIGHT_W];

    // Rotating search starts just above the last released master.
    always_comb begin
        win   = '0;
        found = 1'b0;
        if (MODE == 0) begin
            for (int i = N_MASTER - 1; i >= 0; i--) begin
                if (request[i]) win = IDX_W'(i);
            end
        end else begin
            for (int k = 1; k <= N_MASTER; k++) begin
                if (!found && request[(int'(ptr_q) + k) % N_MASTER]) begin
                    found = 1'b1;
                    win   = IDX_W'((int'(ptr_q) + k) % N_MASTER);
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        rel      = 1'b0;
`ifdef AXIL_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        terr_d   = 1'b0;
        tidx_d   = tidx_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|request) begin
                    state_d      = ACKN;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    idx_d        = win;
                    credit_d     = (win_w == '0) ? WEIGHT_W'(1) : win_w;
`ifdef AXIL_ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            ACKN: begin
                if (rsp_hs) begin
                    if (burst) begin
                        credit_d = credit_q - WEIGHT_W'(1);
`ifdef AXIL_ARB_TIMEOUT_EN
                        cnt_d    = '0;
`endif
                    end else begin
                        rel = 1'b1;
                    end
                end
`ifdef AXIL_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rel    = 1'b1;
                    terr_d = 1'b1;
                    tidx_d = idx_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
                if (rel) begin
                    state_d = IDLE;
                    grant_d = '0;
                    idx_d   = '0;
                    ptr_d   = idx_q;
                end
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            ptr_q    <= IDX_W'(N_MASTER - 1);
            credit_q <= '0;
`ifdef AXIL_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            terr_q   <= 1'b0;
            tidx_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
`ifdef AXIL_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            terr_q   <= terr_d;
            tidx_q   <= tidx_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_idx   = idx_q;

`ifdef AXIL_ARB_TIMEOUT_EN
    assign timeout_err = terr_q;
    assign timeout_idx = tidx_q;
`else
    assign timeout_err = 1'b0;
    assign timeout_idx = '0;
`endif

endmodule

// File: tb/tb_axil_arbiter_wrr.sv
// Bench for axil_arbiter_wrr: three instances (fixed, RR, WRR) on shared stimulus.
// Table of per-cycle vectors checked through an expected-value queue.
module tb_axil_arbiter_wrr;

    localparam int N  = 4;
    localparam int WW = 4;

    typedef struct {
        int         id;
        logic       rstn;
        logic [3:0] req;
        logic       bv;
        logic [3:0] brdy;
        logic [15:0] w;
        int         sel;
        logic [3:0] eg;
        logic       et;
        logic [1:0] eti;
    } vec_t;

    logic        aclk;
    logic        aresetn;
    logic [3:0]  request;
    logic [15:0] weight;
    logic        bvalid;
    logic [3:0]  bready;

    logic [3:0]  g  [3];
    logic        gv [3];
    logic [1:0]  gi [3];
    logic        te [3];
    logic [1:0]  ti [3];

    vec_t vq[$];
    vec_t sbq[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    axil_arbiter_wrr #(.N_MASTER(N), .MODE(0), .WEIGHT_W(WW),
                       .TIMEOUT_CYCLES(16)) u_fp (
        .aclk(aclk), .aresetn(aresetn), .request(request),
        .weight(weight), .grant(g[0]), .grant_valid(gv[0]),
        .grant_idx(gi[0]), .s_axil_bvalid(bvalid),
        .m_axil_bready(bready), .timeout_err(te[0]),
        .timeout_idx(ti[0]));

    axil_arbiter_wrr #(.N_MASTER(N), .MODE(1), .WEIGHT_W(WW),
                       .TIMEOUT_CYCLES(16)) u_rr (
        .aclk(aclk), .aresetn(aresetn), .request(request),
        .weight(weight), .grant(g[1]), .grant_valid(gv[1]),
        .grant_idx(gi[1]), .s_axil_bvalid(bvalid),
        .m_axil_bready(bready), .timeout_err(te[1]),
        .timeout_idx(ti[1]));

    axil_arbiter_wrr #(.N_MASTER(N), .MODE(2), .WEIGHT_W(WW),
                       .TIMEOUT_CYCLES(16)) u_wr (
        .aclk(aclk), .aresetn(aresetn), .request(request),
        .weight(weight), .grant(g[2]), .grant_valid(gv[2]),
        .grant_idx(gi[2]), .s_axil_bvalid(bvalid),
        .m_axil_bready(bready), .timeout_err(te[2]),
        .timeout_idx(ti[2]));

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [1:0] oh2i(input logic [3:0] o);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (o[i]) r = 2'(i);
        return r;
    endfunction

    task automatic add(input logic rstn, input logic [3:0] req,
                       input logic bv, input logic [3:0] brdy,
                       input logic [15:0] w, input int sel,
                       input logic [3:0] eg, input logic et = 1'b0,
                       input logic [1:0] eti = 2'd0);
        vec_t v;
        v.id = vq.size(); v.rstn = rstn; v.req = req; v.bv = bv;
        v.brdy = brdy; v.w = w; v.sel = sel; v.eg = eg;
        v.et = et; v.eti = eti;
        vq.push_back(v);
    endtask

    task automatic miss(input string what, input int id, input int d,
                        input int act, input int req);
        n_miss++;
        $display("FAIL vec%0d dut%0d %s: got %0d want %0d",
                 id, d, what, act, req);
    endtask

    task automatic check_one();
        vec_t e;
        int   s;
        e = sbq.pop_front();
        s = e.sel;
        n_vec++;
        if (g[s] !== e.eg) miss("grant", e.id, s, g[s], e.eg);
        if (gi[s] !== oh2i(e.eg)) miss("grant_idx", e.id, s, gi[s], oh2i(e.eg));
        if (gv[s] !== (|e.eg)) miss("grant_valid", e.id, s, gv[s], |e.eg);
        if (te[s] !== e.et) miss("timeout_err", e.id, s, te[s], e.et);
        if (ti[s] !== e.eti) miss("timeout_idx", e.id, s, ti[s], e.eti);
        for (int d = 0; d < 3; d++) begin
            if ($countones(g[d]) > 1) miss("onehot", e.id, d, g[d], 0);
            if (gv[d] !== (|g[d])) miss("valid_inv", e.id, d, gv[d], |g[d]);
            if (g[d] != 4'd0 && g[d] !== (4'b0001 << gi[d]))
                miss("idx_inv", e.id, d, gi[d], oh2i(g[d]));
            if (g[d] == 4'd0 && gi[d] !== 2'd0)
                miss("idx_zero", e.id, d, gi[d], 0);
        end
    endtask

    localparam logic [3:0]  F  = 4'hf;
    localparam logic [15:0] W1 = 16'h1111;
    localparam logic [15:0] W3 = 16'h1113;

    initial begin
        aresetn = 1'b0; request = '0; weight = W1;
        bvalid = 1'b0; bready = '0;

        // Round robin, all requesting: 0,1,2,3,0 with idle gaps
        add(0, 0, 0, 0, W1, 1, 0);
        for (int m = 0; m < 5; m++) begin
            add(1, F, 0, F, W1, 1, 4'b0001 << (m % 4));
            add(1, F, 0, F, W1, 1, 4'b0001 << (m % 4));
            add(1, F, 1, F, W1, 1, 4'b0000);
        end

        // Fixed priority: master 1 always beats master 3
        add(0, 0, 0, 0, W1, 0, 0);
        for (int m = 0; m < 3; m++) begin
            add(1, 4'b1010, 0, F, W1, 0, 4'b0010);
            add(1, 4'b1010, 1, F, W1, 0, 4'b0000);
        end
        add(1, 4'b1000, 0, F, W1, 0, 4'b1000);
        add(1, 4'b1000, 1, F, W1, 0, 4'b0000);

        // Weighted: master0 weight 3 bursts, weight changes mid-grant ignored
        add(0, 0, 0, 0, W3, 2, 0);
        add(1, 4'b0011, 0, F, W3, 2, 4'b0001);
        add(1, 4'b0011, 1, F, W1, 2, 4'b0001);
        add(1, 4'b0011, 1, F, W1, 2, 4'b0001);
        add(1, 4'b0011, 1, F, W3, 2, 4'b0000);
        add(1, 4'b0011, 0, F, W3, 2, 4'b0010);
        add(1, 4'b0011, 1, F, W3, 2, 4'b0000);
        add(1, 4'b0011, 0, F, W3, 2, 4'b0001);
        add(1, 4'b0011, 1, F, W3, 2, 4'b0001);
        add(1, 4'b0011, 1, F, W3, 2, 4'b0001);
        add(1, 4'b0011, 1, F, W3, 2, 4'b0000);
        add(1, 4'b0001, 0, F, W3, 2, 4'b0001);
        add(1, 4'b0000, 1, F, W3, 2, 4'b0000);
        add(1, 4'b0001, 0, F, 16'h1110, 2, 4'b0001);
        add(1, 4'b0001, 1, F, 16'h1110, 2, 4'b0000);

        // Grant held until the granted master's bready
        add(0, 0, 0, 0, W1, 1, 0);
        add(1, 4'b0100, 0, 0, W1, 1, 4'b0100);
        add(1, 4'b0000, 1, 4'b0010, W1, 1, 4'b0100);
        add(1, 4'b0000, 1, 4'b1011, W1, 1, 4'b0100);
        add(1, 4'b0000, 0, 4'b0100, W1, 1, 4'b0100);
        add(1, 4'b0000, 1, 4'b0100, W1, 1, 4'b0000);
        add(1, 4'b0000, 1, F, W1, 1, 4'b0000);
        add(1, 4'b0010, 1, F, W1, 1, 4'b0010);
        add(1, 4'b0000, 1, F, W1, 1, 4'b0000);

        // Reset mid-grant drops grant and restores the pointer
        add(0, 0, 0, 0, W1, 1, 0);
        add(1, 4'b0100, 0, F, W1, 1, 4'b0100);
        add(1, 4'b0000, 1, F, W1, 1, 4'b0000);
        add(1, 4'b0001, 0, F, W1, 1, 4'b0001);
        add(0, 4'b1100, 0, F, W1, 1, 4'b0000);
        add(1, 4'b1100, 0, F, W1, 1, 4'b0100);

`ifdef AXIL_ARB_TIMEOUT_EN
        add(0, 0, 0, 0, W1, 1, 0);
        add(1, 4'b0010, 0, 0, W1, 1, 4'b0010);
        for (int c = 0; c < 15; c++) add(1, 4'b1010, 0, 0, W1, 1, 4'b0010);
        add(1, 4'b1010, 0, 0, W1, 1, 4'b0000, 1'b1, 2'd1);
        add(1, 4'b1010, 0, 0, W1, 1, 4'b1000, 1'b0, 2'd1);
        for (int c = 0; c < 15; c++)
            add(1, 4'b1010, 0, 0, W1, 1, 4'b1000, 1'b0, 2'd1);
        add(1, 4'b1010, 1, F, W1, 1, 4'b0000, 1'b0, 2'd1);
`endif

        foreach (vq[k]) begin
            @(negedge aclk);
            if (sbq.size() != 0) check_one();
            aresetn = vq[k].rstn;
            request = vq[k].req;
            bvalid  = vq[k].bv;
            bready  = vq[k].brdy;
            weight  = vq[k].w;
            sbq.push_back(vq[k]);
        end
        @(negedge aclk);
        if (sbq.size() != 0) check_one();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
